dac_wavegen: RTL and testbench

- Parametrised successor to the fixed 8-bit DAC driver: produces a WIDTH-bit binary-weighted (R-2R) output code, one waveform per config.
- Waveform modes: hold, sawtooth, triangle, square. Runtime low/high bounds and step.
- Output updates on a prescaled tick. Configuration is loaded through a valid/ready handshake and applied glitch-free on a tick boundary.
- Sits between a control register block and the external resistor ladder pins.

---
 rtl/dac_pkg.sv | 23 ++
 rtl/dac_prescaler.sv | 38 +++
 rtl/dac_wavegen.sv | 194 +++++++++++++++++++
 tb/tb_dac_wavegen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared mode encodings and reset defaults for the DAC waveform blocks.
package dac_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD   = 2'd0,
      MODE_SAW    = 2'd1,
      MODE_TRI    = 2'd2,
      MODE_SQUARE = 2'd3
   } dac_mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dac_dir_e;

   localparam dac_mode_e   DEF_MODE    = MODE_HOLD;
   localparam int unsigned DEF_LO      = 0;
   localparam int unsigned DEF_STEP    = 1;
   localparam logic        DEF_HI_FILL = 1'b1;

endpackage

// File: rtl/dac_prescaler.sv
// Free-running divider: one-clock tick every DIV clocks (DIV >= 1).
module dac_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic nRst,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;

   // run_q keeps tick low in reset even when DIV == 1
   always_comb begin
      run_d = 1'b1;
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign tick = run_q && (cnt_q == LAST);

endmodule

// File: rtl/dac_wavegen.sv
// R-2R DAC waveform generator: hold/saw/tri/square on a prescaled tick.
// Define DAC_WAVEGEN_SYNC_EN to add the 'sync' low-bound marker output.
module dac_wavegen
   import dac_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [MODE_W-1:0] cfg_mode,
   input  logic [WIDTH-1:0]  cfg_lo,
   input  logic [WIDTH-1:0]  cfg_hi,
   input  logic [WIDTH-1:0]  cfg_step,
`ifdef DAC_WAVEGEN_SYNC_EN
   output logic              sync,
`endif
   output logic [WIDTH-1:0]  out,
   output logic              tick
);

   logic tick_s;

   dac_prescaler #(
      .DIV (DIV)
   ) u_presc (
      .clk  (clk),
      .nRst (nRst),
      .tick (tick_s)
   );

   dac_mode_e        mode_q, mode_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] step_q, step_d;
   logic [WIDTH-1:0] out_q, out_d;
   dac_dir_e         dir_q, dir_d;
   logic [WIDTH-1:0] sq_cnt_q, sq_cnt_d;
   logic             sq_hi_q, sq_hi_d;
   logic             ready_q, ready_d;
   logic             pend_q, pend_d;
   dac_mode_e        p_mode_q, p_mode_d;
   logic [WIDTH-1:0] p_lo_q, p_lo_d;
   logic [WIDTH-1:0] p_hi_q, p_hi_d;
   logic [WIDTH-1:0] p_step_q, p_step_d;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   lo_step;
`ifdef DAC_WAVEGEN_SYNC_EN
   logic             sync_evt;
`endif

   always_comb begin
      mode_d   = mode_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      step_d   = step_q;
      out_d    = out_q;
      dir_d    = dir_q;
      sq_cnt_d = sq_cnt_q;
      sq_hi_d  = sq_hi_q;
      ready_d  = ready_q;
      pend_d   = pend_q;
      p_mode_d = p_mode_q;
      p_lo_d   = p_lo_q;
      p_hi_d   = p_hi_q;
      p_step_d = p_step_q;
`ifdef DAC_WAVEGEN_SYNC_EN
      sync_evt = 1'b0;
`endif
      // extra MSB catches the carry so nothing wraps past all-ones
      sum     = {1'b0, out_q} + {1'b0, step_q};
      lo_step = {1'b0, lo_q} + {1'b0, step_q};

      if (tick_s) begin
         if (pend_q) begin
            mode_d   = p_mode_q;
            lo_d     = p_lo_q;
            hi_d     = p_hi_q;
            step_d   = p_step_q;
            out_d    = p_lo_q;
            dir_d    = DIR_UP;
            sq_cnt_d = '0;
            sq_hi_d  = 1'b0;
            pend_d   = 1'b0;
            ready_d  = 1'b1;
`ifdef DAC_WAVEGEN_SYNC_EN
            sync_evt = 1'b1;
`endif
         end else if (lo_q >= hi_q) begin
            out_d = lo_q;
         end else begin
            unique case (mode_q)
               MODE_HOLD: begin
                  out_d = lo_q;
               end
               MODE_SAW: begin
                  if (sum > {1'b0, hi_q}) begin
                     out_d = lo_q;
`ifdef DAC_WAVEGEN_SYNC_EN
                     sync_evt = 1'b1;
`endif
                  end else begin
                     out_d = sum[WIDTH-1:0];
                  end
               end
               MODE_TRI: begin
                  if (dir_q == DIR_UP) begin
                     if (sum >= {1'b0, hi_q}) begin
                        out_d = hi_q;
                        dir_d = DIR_DOWN;
                     end else begin
                        out_d = sum[WIDTH-1:0];
                     end
                  end else if ({1'b0, out_q} <= lo_step) begin
                     out_d = lo_q;
                     dir_d = DIR_UP;
`ifdef DAC_WAVEGEN_SYNC_EN
                     sync_evt = 1'b1;
`endif
                  end else begin
                     out_d = out_q - step_q;
                  end
               end
               MODE_SQUARE: begin
                  if (sq_cnt_q == step_q) begin
                     sq_cnt_d = '0;
                     sq_hi_d  = ~sq_hi_q;
                     out_d    = sq_hi_q ? lo_q : hi_q;
`ifdef DAC_WAVEGEN_SYNC_EN
                     sync_evt = sq_hi_q;
`endif
                  end else begin
                     sq_cnt_d = sq_cnt_q + 1'b1;
                  end
               end
            endcase
         end
      end

      if (cfg_valid && ready_q) begin
         pend_d   = 1'b1;
         ready_d  = 1'b0;
         p_mode_d = dac_mode_e'(cfg_mode);
         p_lo_d   = cfg_lo;
         p_hi_d   = cfg_hi;
         p_step_d = cfg_step;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         mode_q   <= DEF_MODE;
         lo_q     <= WIDTH'(DEF_LO);
         hi_q     <= {WIDTH{DEF_HI_FILL}};
         step_q   <= WIDTH'(DEF_STEP);
         out_q    <= '0;
         dir_q    <= DIR_UP;
         sq_cnt_q <= '0;
         sq_hi_q  <= 1'b0;
         ready_q  <= 1'b1;
         pend_q   <= 1'b0;
         p_mode_q <= MODE_HOLD;
         p_lo_q   <= '0;
         p_hi_q   <= '0;
         p_step_q <= '0;
      end else begin
         mode_q   <= mode_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         step_q   <= step_d;
         out_q    <= out_d;
         dir_q    <= dir_d;
         sq_cnt_q <= sq_cnt_d;
         sq_hi_q  <= sq_hi_d;
         ready_q  <= ready_d;
         pend_q   <= pend_d;
         p_mode_q <= p_mode_d;
         p_lo_q   <= p_lo_d;
         p_hi_q   <= p_hi_d;
         p_step_q <= p_step_d;
      end
   end

   assign out       = out_q;
   assign tick      = tick_s;
   assign cfg_ready = ready_q;
`ifdef DAC_WAVEGEN_SYNC_EN
   assign sync      = sync_evt;
`endif

endmodule

// File: tb/tb_dac_wavegen.sv
// Directed plus randomized bench for dac_wavegen against a tick-level model.
module tb_dac_wavegen;

   localparam int W   = 8;
   localparam int DIV = 4;
   localparam int MAXC = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         nRst = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [1:0]   cfg_mode = '0;
   logic [W-1:0] cfg_lo = '0;
   logic [W-1:0] cfg_hi = '0;
   logic [W-1:0] cfg_step = '0;
   logic         cfg_ready;
   logic [W-1:0] out;
   logic         tick;
`ifdef DAC_WAVEGEN_SYNC_EN
   logic         sync;
`endif

   always #5 clk = ~clk;

   dac_wavegen #(
      .WIDTH (W),
      .DIV   (DIV)
   ) dut (
      .clk       (clk),
      .nRst      (nRst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_mode  (cfg_mode),
      .cfg_lo    (cfg_lo),
      .cfg_hi    (cfg_hi),
      .cfg_step  (cfg_step),
`ifdef DAC_WAVEGEN_SYNC_EN
      .sync      (sync),
`endif
      .out       (out),
      .tick      (tick)
   );

   int n_cmp = 0;
   int n_err = 0;
   int c = 0;

   int m_mode, m_lo, m_hi, m_step, m_out, m_k;
   bit m_up, m_pend, m_ready;
   int p_mode, p_lo, p_hi, p_step;
   int obs[$];
   int acc_c, app_c;

   task automatic chk(string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_lo = 0; m_hi = MAXC; m_step = 1;
      m_out = 0; m_up = 1; m_k = 0;
      m_pend = 0; m_ready = 1;
   endtask

   task automatic cyc();
      bit t, s, rdy_now;
      t = (c % DIV) == (DIV - 1);
      s = 0;
      rdy_now = m_ready;
      chk("tick", tick, t);
      chk("ready", cfg_ready, m_ready);
      chk("out", out, m_out);
      if (t) begin
         if (m_pend) begin
            m_mode = p_mode; m_lo = p_lo; m_hi = p_hi; m_step = p_step;
            m_out = m_lo; m_up = 1; m_k = 0;
            m_pend = 0; m_ready = 1; s = 1;
            app_c = c;
            obs.delete();
         end else begin
            m_k++;
            if (m_lo >= m_hi) m_out = m_lo;
            else case (m_mode)
               0: m_out = m_lo;
               1: if (m_out + m_step > m_hi) begin
                     m_out = m_lo; s = 1;
                  end else m_out = m_out + m_step;
               2: if (m_up) begin
                     if (m_out + m_step >= m_hi) begin
                        m_out = m_hi; m_up = 0;
                     end else m_out = m_out + m_step;
                  end else if (m_out <= m_lo + m_step) begin
                     m_out = m_lo; m_up = 1; s = 1;
                  end else m_out = m_out - m_step;
               default: begin
                  m_out = ((m_k / (m_step + 1)) % 2) ? m_hi : m_lo;
                  if ((m_k % (m_step + 1)) == 0 && m_out == m_lo) s = 1;
               end
            endcase
         end
      end
`ifdef DAC_WAVEGEN_SYNC_EN
      chk("sync", sync, s);
`endif
      if (cfg_valid && rdy_now) begin
         m_pend = 1; m_ready = 0; acc_c = c;
         p_mode = cfg_mode; p_lo = cfg_lo; p_hi = cfg_hi; p_step = cfg_step;
      end
      @(posedge clk);
      #1;
      c++;
      if (t) obs.push_back(out);
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic send(input int md, input int lo, input int hi, input int st);
      cfg_valid = 1'b1;
      cfg_mode = md[1:0]; cfg_lo = lo[W-1:0];
      cfg_hi = hi[W-1:0]; cfg_step = st[W-1:0];
      cyc();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int b = 0;
      while (!m_ready && b < 100) begin
         cyc();
         b++;
      end
      chk("ready_timeout", b < 100, 1);
   endtask

   task automatic align_tick_ready(input int phase);
      int b = 0;
      while (!((c % DIV) == phase && m_ready) && b < 100) begin
         cyc();
         b++;
      end
      chk("align_timeout", b < 100, 1);
   endtask

   task automatic chk_seq(string tag, input int e[$]);
      chk({tag, "_len"}, obs.size() >= e.size(), 1);
      foreach (e[i]) if (i < obs.size()) chk(tag, obs[i], e[i]);
   endtask

   initial begin
      int e[$];
      int md, lo, hi, st;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_ready", cfg_ready, 1);
      nRst = 1'b1;
      c = 0;

      run(12);

      send(1, 10, 50, 15);
      wait_ready();
      run(5 * DIV);
      e = {10, 25, 40, 10, 25};
      chk_seq("saw", e);

      send(2, 0, 255, 100);
      wait_ready();
      run(8 * DIV);
      e = {0, 100, 200, 255, 155, 55, 0, 100};
      chk_seq("tri", e);

      send(3, 20, 200, 2);
      wait_ready();
      run(7 * DIV);
      e = {20, 20, 20, 200, 200, 200, 20};
      chk_seq("square", e);

      align_tick_ready(DIV - 1);
      send(1, 0, 200, 7);
      cfg_valid = 1'b1;
      cfg_mode = 2'd3; cfg_lo = 8'd5; cfg_hi = 8'd6; cfg_step = 8'd0;
      run(2);
      cfg_valid = 1'b0;
      wait_ready();
      chk("apply_latency", app_c - acc_c, DIV);
      run(3 * DIV);

      for (int i = 0; i < 25; i++) begin
         md = $urandom_range(0, 3);
         lo = $urandom_range(0, MAXC);
         hi = ($urandom_range(0, 3) == 0) ? MAXC : $urandom_range(0, MAXC);
         st = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 120);
         run($urandom_range(0, 6));
         send(md, lo, hi, st);
         run($urandom_range(0, 10 * DIV));
      end

      wait_ready();
      send(1, 100, 100, 5);
      wait_ready();
      run(3 * DIV);
      chk("hold_eq", out, 100);

      align_tick_ready(0);
      send(2, 1, 9, 1);
      run(1);
      nRst = 1'b0;
      #1;
      chk("arst_out", out, 0);
      chk("arst_ready", cfg_ready, 1);
      chk("arst_tick", tick, 0);
      model_reset();
      @(posedge clk);
      #1;
      nRst = 1'b1;
      c = 0;
      run(4 * DIV);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
